// File: rtl/xv_pkg.sv
// Shared definitions for the video subsystem.
package xv;

  // Which client owns a VRAM access in flight.
  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_VID,
    OWN_CPU,
    OWN_BLIT
  } vram_owner_t;

  // Consecutive CPU wins over a waiting blitter before the blitter is forced a slot.
  localparam int BLIT_STARVE_DEFAULT = 4;

endpackage

// File: rtl/vram_arbiter.sv
// Shares the single-port 64Kx16 VRAM between video scan-out, the CPU register
// interface and the blitter. At most one access is issued per cycle, registered
// onto the vram_* bus one cycle after the grant. Read data returns two cycles
// after the grant and is steered to its owner.
module vram_arbiter
  import xv::*;
#(
  parameter int BLIT_STARVE = BLIT_STARVE_DEFAULT
) (
  input  logic        clk,
  input  logic        reset_n,
  // video scan-out
  input  logic        vid_req_i,
  input  logic [15:0] vid_addr_i,
  output logic [15:0] vid_data_o,
  output logic        vid_valid_o,
  // CPU register interface
  input  logic        cpu_rd_i,
  input  logic        cpu_wr_i,
  input  logic [15:0] cpu_addr_i,
  input  logic [15:0] cpu_data_i,
  output logic        cpu_busy_o,
  output logic [15:0] cpu_data_o,
  output logic        cpu_valid_o,
  // blitter
  input  logic        blit_req_i,
  input  logic        blit_wr_i,
  input  logic [15:0] blit_addr_i,
  input  logic [15:0] blit_data_i,
  output logic        blit_ack_o,
  output logic [15:0] blit_data_o,
  output logic        blit_valid_o,
  // VRAM macro
  output logic        vram_sel_o,
  output logic        vram_wr_o,
  output logic [15:0] vram_addr_o,
  output logic [15:0] vram_data_o,
  input  logic [15:0] vram_data_i
);

  localparam logic [2:0] STARVE_MAX = 3'(BLIT_STARVE);

  // grant decision
  vram_owner_t gnt;
  logic        blit_req_eff;
  logic        cpu_pend;

  // CPU slot: one buffered request; iss marks a read already on its way
  logic        slot_vld_q, slot_vld_d;
  logic        slot_iss_q, slot_iss_d;
  logic        slot_wr_q, slot_wr_d;
  logic [15:0] slot_addr_q, slot_addr_d;
  logic [15:0] slot_data_q, slot_data_d;

  // registered VRAM bus and the owner pipeline
  logic        sel_q, sel_d;
  logic        wr_q, wr_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  vram_owner_t bus_owner_q, bus_owner_d;
  vram_owner_t rd_owner_q, rd_owner_d;
  logic        blit_ack_q, blit_ack_d;
  logic [2:0]  starve_cnt_q, starve_cnt_d;

  // Pick this cycle's winner. A blitter request seen in its own ack cycle has
  // already been served, so it is masked to avoid a duplicate grant.
  always_comb begin
    blit_req_eff = blit_req_i & ~blit_ack_q;
    cpu_pend     = slot_vld_q & ~slot_iss_q;
    gnt          = OWN_NONE;
    if (vid_req_i)
      gnt = OWN_VID;
    else if (blit_req_eff && (starve_cnt_q == STARVE_MAX))
      gnt = OWN_BLIT;
    else if (cpu_pend)
      gnt = OWN_CPU;
    else if (blit_req_eff)
      gnt = OWN_BLIT;
  end

  // CPU slot: writes free on grant, reads free once their access is on the bus
  // so busy drops in the cycle the read data returns.
  always_comb begin
    slot_vld_d  = slot_vld_q;
    slot_iss_d  = slot_iss_q;
    slot_wr_d   = slot_wr_q;
    slot_addr_d = slot_addr_q;
    slot_data_d = slot_data_q;
    if (slot_iss_q) begin
      slot_vld_d = 1'b0;
      slot_iss_d = 1'b0;
    end else if (gnt == OWN_CPU) begin
      if (slot_wr_q)
        slot_vld_d = 1'b0;
      else
        slot_iss_d = 1'b1;
    end
    // strobes are only taken while the slot is empty; rd+wr counts as a write
    if (!slot_vld_q && (cpu_rd_i || cpu_wr_i)) begin
      slot_vld_d  = 1'b1;
      slot_iss_d  = 1'b0;
      slot_wr_d   = cpu_wr_i;
      slot_addr_d = cpu_addr_i;
      slot_data_d = cpu_data_i;
    end
  end

  // Next VRAM bus state, read-owner tag, blitter ack and starvation count.
  always_comb begin
    sel_d        = (gnt != OWN_NONE);
    wr_d         = 1'b0;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    blit_ack_d   = (gnt == OWN_BLIT);
    starve_cnt_d = starve_cnt_q;
    case (gnt)
      OWN_VID: begin
        addr_d = vid_addr_i;
      end
      OWN_CPU: begin
        wr_d   = slot_wr_q;
        addr_d = slot_addr_q;
        if (slot_wr_q) wdata_d = slot_data_q;
      end
      OWN_BLIT: begin
        wr_d   = blit_wr_i;
        addr_d = blit_addr_i;
        if (blit_wr_i) wdata_d = blit_data_i;
      end
      default: ;
    endcase
    bus_owner_d = (sel_d && !wr_d) ? gnt : OWN_NONE;
    rd_owner_d  = bus_owner_q;
    if ((gnt == OWN_BLIT) || !blit_req_eff)
      starve_cnt_d = '0;
    else if ((gnt == OWN_CPU) && (starve_cnt_q != STARVE_MAX))
      starve_cnt_d = starve_cnt_q + 3'd1;
  end

  // State registers; reset discards any in-flight access and pending request.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slot_vld_q   <= 1'b0;
      slot_iss_q   <= 1'b0;
      slot_wr_q    <= 1'b0;
      slot_addr_q  <= '0;
      slot_data_q  <= '0;
      sel_q        <= 1'b0;
      wr_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      bus_owner_q  <= OWN_NONE;
      rd_owner_q   <= OWN_NONE;
      blit_ack_q   <= 1'b0;
      starve_cnt_q <= '0;
    end else begin
      slot_vld_q   <= slot_vld_d;
      slot_iss_q   <= slot_iss_d;
      slot_wr_q    <= slot_wr_d;
      slot_addr_q  <= slot_addr_d;
      slot_data_q  <= slot_data_d;
      sel_q        <= sel_d;
      wr_q         <= wr_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      bus_owner_q  <= bus_owner_d;
      rd_owner_q   <= rd_owner_d;
      blit_ack_q   <= blit_ack_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  // Read data is gated by its owner so idle data outputs stay at zero.
  always_comb begin
    vid_valid_o  = (rd_owner_q == OWN_VID);
    cpu_valid_o  = (rd_owner_q == OWN_CPU);
    blit_valid_o = (rd_owner_q == OWN_BLIT);
    vid_data_o   = vid_valid_o  ? vram_data_i : '0;
    cpu_data_o   = cpu_valid_o  ? vram_data_i : '0;
    blit_data_o  = blit_valid_o ? vram_data_i : '0;
    cpu_busy_o   = slot_vld_q;
    blit_ack_o   = blit_ack_q;
    vram_sel_o   = sel_q;
    vram_wr_o    = wr_q;
    vram_addr_o  = addr_q;
    vram_data_o  = wdata_q;
  end

endmodule
